// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate-multiplier pipeline:
// mode encoding, truncation mask construction and parameter legality.
package approx_mult_pkg;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    // Widest product supported (N=32); masks are built at this width and sliced.
    localparam int MAX_PROD_W = 64;

    function automatic logic [MAX_PROD_W-1:0] trunc_mask(input int n, input int cut);
        logic [MAX_PROD_W-1:0] m;
        m = '0;
        for (int c = 0; c < MAX_PROD_W; c++) begin
            if (c >= cut && c < 2 * n) begin
                m[c] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic bit params_legal(input int n, input int l, input int cut,
                                        input int tag_w, input int cnt_w);
        return (n >= 4) && (n <= 32) &&
               (l >= 1) && (l <= n - 1) &&
               (cut >= 0) && (cut <= 2 * n) &&
               (tag_w >= 1) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/approx_lo_rows.sv
// Sums the L low partial-product rows twice: exactly, and with every column
// below CUT discarded. The difference between the two is the error distance.
module approx_lo_rows
    import approx_mult_pkg::*;
#(
    parameter int N   = 8,
    parameter int L   = 2,
    parameter int CUT = 6
) (
    input  logic [N-1:0]   y,
    input  logic [L-1:0]   x_lo,
    output logic [2*N-1:0] lo_exact,
    output logic [2*N-1:0] lo_trunc
);

    localparam logic [MAX_PROD_W-1:0] MASK_FULL = trunc_mask(N, CUT);
    localparam logic [2*N-1:0]        MASK      = MASK_FULL[2*N-1:0];

    logic [2*N-1:0] pp;

    always_comb begin
        lo_exact = '0;
        lo_trunc = '0;
        pp       = '0;
        for (int i = 0; i < L; i++) begin
            pp       = {{N{1'b0}}, y & {N{x_lo[i]}}} << i;
            lo_exact = lo_exact + pp;
            lo_trunc = lo_trunc + (pp & MASK);
        end
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage valid/ready N x N multiplier with selectable exact/approximate
// result, error-distance output, tag passthrough and saturating approx counter.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int N     = 8,
    parameter int L     = 2,
    parameter int CUT   = 6,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    input  logic             mode,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   z,
    output logic [2*N-1:0]   err,
    output logic             mode_out,
    output logic [TAG_W-1:0] tag_out,
    output logic [CNT_W-1:0] approx_cnt,
    input  logic             cnt_clr
);

    if (!params_legal(N, L, CUT, TAG_W, CNT_W)) begin : g_param_check
        $error("approx_mult_pipe: illegal parameter combination");
    end

    logic             s1_valid;
    logic [2*N-1:0]   s1_hi;
    logic [2*N-1:0]   s1_lo_exact;
    logic [2*N-1:0]   s1_lo_trunc;
    mode_e            s1_mode;
    logic [TAG_W-1:0] s1_tag;

    logic             s1_en;
    logic             s2_en;

    logic [2*N-1:0]   hi_prod;
    logic [2*N-1:0]   lo_exact;
    logic [2*N-1:0]   lo_trunc;

    logic [2*N-1:0]   hi_shift;
    logic [2*N-1:0]   exact_sum;
    logic [2*N-1:0]   approx_sum;
    logic [2*N-1:0]   lo_diff;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // The upper rows are identical in both modes, so they are one shared product.
    assign hi_prod = {{N{1'b0}}, y} * {{(N+L){1'b0}}, x[N-1:L]};

    approx_lo_rows #(
        .N   (N),
        .L   (L),
        .CUT (CUT)
    ) u_lo_rows (
        .y        (y),
        .x_lo     (x[L-1:0]),
        .lo_exact (lo_exact),
        .lo_trunc (lo_trunc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_hi       <= '0;
            s1_lo_exact <= '0;
            s1_lo_trunc <= '0;
            s1_mode     <= MODE_EXACT;
            s1_tag      <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_hi       <= hi_prod;
                s1_lo_exact <= lo_exact;
                s1_lo_trunc <= lo_trunc;
                s1_mode     <= mode_e'(mode);
                s1_tag      <= tag_in;
            end
        end
    end

    assign hi_shift   = s1_hi << L;
    assign exact_sum  = hi_shift + s1_lo_exact;
    assign approx_sum = hi_shift + s1_lo_trunc;
    assign lo_diff    = s1_lo_exact - s1_lo_trunc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= '0;
            err       <= '0;
            mode_out  <= 1'b0;
            tag_out   <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                z        <= (s1_mode == MODE_APPROX) ? approx_sum : exact_sum;
                err      <= (s1_mode == MODE_APPROX) ? lo_diff : '0;
                mode_out <= (s1_mode == MODE_APPROX);
                tag_out  <= s1_tag;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            approx_cnt <= '0;
        end else if (cnt_clr) begin
            approx_cnt <= '0;
        end else if (out_valid && out_ready && mode_out &&
                     (approx_cnt != {CNT_W{1'b1}})) begin
            approx_cnt <= approx_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed self-checking bench for approx_mult_pipe (N=8, L=2, CUT=6, CNT_W=4).
module tb_approx_mult_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        mode;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic [15:0] err;
    logic        mode_out;
    logic [3:0]  tag_out;
    logic [3:0]  approx_cnt;
    logic        cnt_clr;

    int checks   = 0;
    int failures = 0;

    approx_mult_pipe #(
        .N     (8),
        .L     (2),
        .CUT   (6),
        .TAG_W (4),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .mode       (mode),
        .tag_in     (tag_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .z          (z),
        .err        (err),
        .mode_out   (mode_out),
        .tag_out    (tag_out),
        .approx_cnt (approx_cnt),
        .cnt_clr    (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic straight from the row definitions, with CUT=6 mask 0xFFC0.
    function automatic logic [15:0] model_z(input logic [7:0] xv, input logic [7:0] yv,
                                            input logic m);
        logic [15:0] acc;
        if (!m) return 16'(xv) * 16'(yv);
        acc = (16'(yv) * 16'(xv[7:2])) << 2;
        for (int i = 0; i < 2; i++) begin
            if (xv[i]) acc = acc + ((16'(yv) << i) & 16'hFFC0);
        end
        return acc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        x = '0; y = '0; mode = 1'b0; tag_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (z !== 16'd0) begin failures++; $display("[TB] FAIL reset_z got=%0d exp=0", z); end
        checks++; if (err !== 16'd0) begin failures++; $display("[TB] FAIL reset_err got=%0d exp=0", err); end
        checks++; if (approx_cnt !== 4'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", approx_cnt); end
        checks++; if (tag_out !== 4'd0 || mode_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_tag_mode got=%0d/%0b exp=0/0", tag_out, mode_out); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_max_operands();
        x = 8'd255; y = 8'd255; mode = 1'b1; tag_in = 4'hA; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL max_latency_early got=%0b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL max_latency got=%0b exp=1", out_valid); end
        checks++; if (z !== 16'd64900) begin failures++; $display("[TB] FAIL max_z got=%0d exp=64900", z); end
        checks++; if (err !== 16'd125) begin failures++; $display("[TB] FAIL max_err got=%0d exp=125", err); end
        checks++; if (tag_out !== 4'hA || mode_out !== 1'b1) begin failures++; $display("[TB] FAIL max_tag_mode got=%0h/%0b exp=a/1", tag_out, mode_out); end
        step();
        checks++; if (out_valid !== 1'b1 || z !== 16'd64900) begin failures++; $display("[TB] FAIL max_hold got=%0b/%0d exp=1/64900", out_valid, z); end
        checks++; if (approx_cnt !== 4'd0) begin failures++; $display("[TB] FAIL max_cnt_before got=%0d exp=0", approx_cnt); end
        out_ready = 1'b1;
        step();
        checks++; if (approx_cnt !== 4'd1) begin failures++; $display("[TB] FAIL max_cnt_after got=%0d exp=1", approx_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL max_drained got=%0b exp=0", out_valid); end
    endtask

    task automatic test_directed();
        logic [7:0]  xs   [4] = '{8'd3, 8'd3, 8'd4, 8'd1};
        logic [7:0]  ys   [4] = '{8'd1, 8'd1, 8'd100, 8'd128};
        logic        ms   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] ez   [4] = '{16'd0, 16'd3, 16'd400, 16'd128};
        logic [15:0] ee   [4] = '{16'd3, 16'd0, 16'd0, 16'd0};
        logic [3:0]  ecnt [4] = '{4'd2, 4'd2, 4'd3, 4'd4};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = xs[i]; y = ys[i]; mode = ms[i]; tag_in = 4'(i + 1); in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            checks++; if (out_valid !== 1'b1 || z !== ez[i]) begin failures++; $display("[TB] FAIL directed%0d_z got=%0b/%0d exp=1/%0d", i, out_valid, z, ez[i]); end
            checks++; if (err !== ee[i] || mode_out !== ms[i]) begin failures++; $display("[TB] FAIL directed%0d_err got=%0d/%0b exp=%0d/%0b", i, err, mode_out, ee[i], ms[i]); end
            step();
            checks++; if (approx_cnt !== ecnt[i]) begin failures++; $display("[TB] FAIL directed%0d_cnt got=%0d exp=%0d", i, approx_cnt, ecnt[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_z_q[$];
        logic [15:0] exp_e_q[$];
        logic [3:0]  exp_t_q[$];
        logic        exp_m_q[$];
        logic [15:0] held_z, held_err, ez, ee;
        logic [3:0]  held_tag, et;
        logic        held_valid, em;
        bit          saw_backpressure, bad_ready;
        int          sent, recv;
        held_valid = 1'b0; held_z = '0; held_err = '0; held_tag = '0;
        saw_backpressure = 0; bad_ready = 0; sent = 0; recv = 0;
        for (int cyc = 0; cyc < 200 && recv < 16; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            if (sent < 16) begin
                in_valid = 1'b1;
                x = 8'(sent * 37 + 11); y = 8'(255 - sent * 13);
                mode = sent[0]; tag_in = sent[3:0];
            end else begin
                in_valid = 1'b0;
            end
            #3;
            if (held_valid) begin
                checks++;
                if (out_valid !== 1'b1 || z !== held_z || err !== held_err || tag_out !== held_tag) begin
                    failures++; $display("[TB] FAIL b2b_stall_hold got=%0b/%0d/%0h exp=1/%0d/%0h", out_valid, z, tag_out, held_z, held_tag);
                end
            end
            if (!in_ready) saw_backpressure = 1;
            if (out_ready && !in_ready) bad_ready = 1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_z_q.size() == 0) begin
                    failures++; $display("[TB] FAIL b2b_extra got=tag%0h exp=none", tag_out);
                end else begin
                    ez = exp_z_q.pop_front(); ee = exp_e_q.pop_front();
                    et = exp_t_q.pop_front(); em = exp_m_q.pop_front();
                    if (z !== ez || err !== ee || tag_out !== et || mode_out !== em) begin
                        failures++; $display("[TB] FAIL b2b_result got=%0d/%0d/%0h/%0b exp=%0d/%0d/%0h/%0b", z, err, tag_out, mode_out, ez, ee, et, em);
                    end
                end
                recv++;
            end
            held_valid = out_valid && !out_ready;
            held_z = z; held_err = err; held_tag = tag_out;
            if (in_valid && in_ready) begin
                exp_z_q.push_back(model_z(x, y, mode));
                exp_e_q.push_back(model_z(x, y, 1'b0) - model_z(x, y, mode));
                exp_t_q.push_back(tag_in);
                exp_m_q.push_back(mode);
                sent++;
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (recv !== 16 || sent !== 16) begin failures++; $display("[TB] FAIL b2b_count got=%0d/%0d exp=16/16", sent, recv); end
        checks++; if (!saw_backpressure) begin failures++; $display("[TB] FAIL b2b_backpressure got=never_low exp=low_once"); end
        checks++; if (bad_ready) begin failures++; $display("[TB] FAIL b2b_ready_while_draining got=0 exp=1"); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_duplicate got=%0b exp=0", out_valid); end
        checks++; if (approx_cnt !== 4'd12) begin failures++; $display("[TB] FAIL b2b_cnt got=%0d exp=12", approx_cnt); end
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++; if (approx_cnt !== 4'd0) begin failures++; $display("[TB] FAIL sat_clear got=%0d exp=0", approx_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            x = 8'(i + 1); y = 8'd3; mode = 1'b1; tag_in = 4'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        checks++; if (approx_cnt !== 4'd15) begin failures++; $display("[TB] FAIL sat_hold got=%0d exp=15", approx_cnt); end
        x = 8'd9; y = 8'd9; mode = 1'b1; tag_in = 4'h6; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        cnt_clr = 1'b1;
        checks++; if (out_valid !== 1'b1 || mode_out !== 1'b1) begin failures++; $display("[TB] FAIL sat_clr_setup got=%0b/%0b exp=1/1", out_valid, mode_out); end
        step();
        cnt_clr = 1'b0;
        checks++; if (approx_cnt !== 4'd0) begin failures++; $display("[TB] FAIL sat_clr_priority got=%0d exp=0", approx_cnt); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        x = 8'd7; y = 8'd7; mode = 1'b1; tag_in = 4'h2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        checks++; if (approx_cnt !== 4'd1) begin failures++; $display("[TB] FAIL areset_pre_cnt got=%0d exp=1", approx_cnt); end
        out_ready = 1'b0;
        x = 8'd200; y = 8'd50; mode = 1'b1; tag_in = 4'h3; in_valid = 1'b1;
        step();
        x = 8'd100; y = 8'd25; tag_in = 4'h4;
        step();
        in_valid = 1'b0;
        #2;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL areset_full got=%0b/%0b exp=0/1", in_ready, out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || z !== 16'd0 || err !== 16'd0) begin failures++; $display("[TB] FAIL areset_outputs got=%0b/%0d/%0d exp=0/0/0", out_valid, z, err); end
        checks++; if (approx_cnt !== 4'd0 || tag_out !== 4'd0 || mode_out !== 1'b0) begin failures++; $display("[TB] FAIL areset_cnt got=%0d/%0h/%0b exp=0/0/0", approx_cnt, tag_out, mode_out); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL areset_in_ready got=%0b exp=1", in_ready); end
        x = 8'd255; y = 8'd255; mode = 1'b0; tag_in = 4'h7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_stale got=%0b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || z !== 16'd65025 || err !== 16'd0 || tag_out !== 4'h7) begin
            failures++; $display("[TB] FAIL areset_first_beat got=%0b/%0d/%0d/%0h exp=1/65025/0/7", out_valid, z, err, tag_out);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_max_operands();
        test_directed();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
